// File: rtl/jtframe_video_pkg.sv
// Shared video-timing definitions: line-lock FSM encoding and tick-counter width.
package jtframe_video_pkg;

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    // Tick counters must hold one full doubled line of the widest supported mode
    function automatic int cw_f(input int hlen);
        return (hlen <= 32'sd512) ? 32'sd10 : 32'sd11;
    endfunction

endpackage

// File: rtl/jtframe_edge.sv
// Registered edge detector: keeps a cen-sampled copy of sig_i and flags
// rising/falling edges against that copy.
module jtframe_edge (
    input  logic clk,
    input  logic rst,
    input  logic cen_i,
    input  logic sig_i,
    output logic sig_q_o,
    output logic rise_o,
    output logic fall_o
);

    logic sig_d;
    logic sig_q;

    // Next value of the sampled copy; only advances on the clock enable
    always_comb begin
        sig_d = sig_q;
        if (cen_i) begin
            sig_d = sig_i;
        end else begin
            sig_d = sig_q;
        end
    end

    // Sampled copy register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_q_o = sig_q;
    assign rise_o  = sig_i & ~sig_q;
    assign fall_o  = ~sig_i & sig_q;

endmodule

// File: rtl/jtframe_scan2x_sync.sv
// Output timing stage after the scan doubler: locks to the doubled line period,
// builds DE from measured HS width and line length, aligns VS to doubled lines.
module jtframe_scan2x_sync
    import jtframe_video_pkg::*;
#(
    parameter int COLORW = 4,
    parameter int HLEN   = 512,
    parameter int HBP    = 16,
    parameter int HFP    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pxl2_cen,
    input  logic [3*COLORW-1:0]     x2_pxl,
    input  logic                    x2_HS,
    input  logic                    VS,
    input  logic                    LVBL,
    output logic [3*COLORW-1:0]     vga_pxl,
    output logic                    vga_HS,
    output logic                    vga_VS,
    output logic                    vga_DE,
    output logic                    locked,
    output logic [cw_f(HLEN)-1:0]   line_len
);

    localparam int              CW    = cw_f(HLEN);
    localparam int              PW    = 3*COLORW;
    localparam logic [CW-1:0]   ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   HMAX  = {CW{1'b1}};
    localparam logic [CW:0]     HBP_X = (CW+1)'(HBP);
    localparam logic [CW:0]     HFP_X = (CW+1)'(HFP);

    logic           hs_q;
    logic           hs_rise_s;
    logic           hs_fall_s;

    logic [CW-1:0]  hcnt_q, hcnt_d;
    logic [CW-1:0]  hsw_q,  hsw_d;
    logic [CW-1:0]  len_q,  len_d;
    logic [1:0]     st_q,   st_d;
    logic           lock_q, lock_d;
    logic           vs1_q,  vs1_d;
    logic           vs2_q,  vs2_d;
    logic           lvbl1_q, lvbl1_d;
    logic           lvbl2_q, lvbl2_d;
    logic           vsync_q, vsync_d;
    logic           vblank_q, vblank_d;
    logic           de_q,   de_d;
    logic [PW-1:0]  pxl_q,  pxl_d;

    logic           sat_s;
    logic [CW-1:0]  per_s;
    logic [CW:0]    de_lo_s;
    logic           hde_s;
    logic           de_s;

    jtframe_edge u_hs_edge (
        .clk     (clk),
        .rst     (rst),
        .cen_i   (pxl2_cen),
        .sig_i   (x2_HS),
        .sig_q_o (hs_q),
        .rise_o  (hs_rise_s),
        .fall_o  (hs_fall_s)
    );

    // Horizontal window: extra bit keeps an empty window from underflowing
    always_comb begin
        sat_s   = (hcnt_q == HMAX);
        per_s   = hcnt_q + ONE;
        de_lo_s = {1'b0, hsw_q} + HBP_X;
        hde_s   = ({1'b0, hcnt_q} >= de_lo_s) &&
                  (({1'b0, hcnt_q} + HFP_X) < {1'b0, len_q}) &&
                  !x2_HS;
        de_s    = hde_s & ~vblank_q & lock_q;
    end

    // Next-state logic; nothing moves unless pxl2_cen is high
    always_comb begin
        hcnt_d   = hcnt_q;
        hsw_d    = hsw_q;
        len_d    = len_q;
        st_d     = st_q;
        lock_d   = lock_q;
        vs1_d    = vs1_q;
        vs2_d    = vs2_q;
        lvbl1_d  = lvbl1_q;
        lvbl2_d  = lvbl2_q;
        vsync_d  = vsync_q;
        vblank_d = vblank_q;
        de_d     = de_q;
        pxl_d    = pxl_q;
        if (pxl2_cen) begin
            vs1_d   = VS;
            vs2_d   = vs1_q;
            lvbl1_d = LVBL;
            lvbl2_d = lvbl1_q;
            de_d    = de_s;
            pxl_d   = de_s ? x2_pxl : {PW{1'b0}};
            if (hs_rise_s) begin
                hcnt_d   = {CW{1'b0}};
                vsync_d  = vs2_q;
                vblank_d = ~lvbl2_q;
                case (st_q)
                    ST_SEARCH: begin
                        st_d   = ST_MEASURE;
                        lock_d = 1'b0;
                    end
                    ST_MEASURE: begin
                        len_d = per_s;
                        if (per_s == len_q) begin
                            st_d   = ST_LOCKED;
                            lock_d = 1'b1;
                        end else begin
                            st_d   = ST_MEASURE;
                            lock_d = 1'b0;
                        end
                    end
                    ST_LOCKED: begin
                        if (per_s != len_q) begin
                            st_d   = ST_MEASURE;
                            lock_d = 1'b0;
                            len_d  = per_s;
                        end else begin
                            st_d   = ST_LOCKED;
                            lock_d = 1'b1;
                        end
                    end
                    default: begin
                        st_d   = ST_SEARCH;
                        lock_d = 1'b0;
                    end
                endcase
            end else if (sat_s) begin
                // HS lost: hold the counter at full scale and restart acquisition
                hcnt_d = hcnt_q;
                st_d   = ST_SEARCH;
                lock_d = 1'b0;
                if (hs_fall_s) begin
                    hsw_d = HMAX;
                end else begin
                    hsw_d = hsw_q;
                end
            end else begin
                hcnt_d = hcnt_q + ONE;
                if (hs_fall_s) begin
                    hsw_d = per_s;
                end else begin
                    hsw_d = hsw_q;
                end
            end
        end else begin
            hcnt_d = hcnt_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q   <= {CW{1'b0}};
            hsw_q    <= {CW{1'b0}};
            len_q    <= {CW{1'b0}};
            st_q     <= ST_SEARCH;
            lock_q   <= 1'b0;
            vs1_q    <= 1'b0;
            vs2_q    <= 1'b0;
            lvbl1_q  <= 1'b0;
            lvbl2_q  <= 1'b0;
            vsync_q  <= 1'b0;
            vblank_q <= 1'b1;
            de_q     <= 1'b0;
            pxl_q    <= {PW{1'b0}};
        end else begin
            hcnt_q   <= hcnt_d;
            hsw_q    <= hsw_d;
            len_q    <= len_d;
            st_q     <= st_d;
            lock_q   <= lock_d;
            vs1_q    <= vs1_d;
            vs2_q    <= vs2_d;
            lvbl1_q  <= lvbl1_d;
            lvbl2_q  <= lvbl2_d;
            vsync_q  <= vsync_d;
            vblank_q <= vblank_d;
            de_q     <= de_d;
            pxl_q    <= pxl_d;
        end
    end

    assign vga_pxl  = pxl_q;
    assign vga_HS   = hs_q;
    assign vga_VS   = vsync_q;
    assign vga_DE   = de_q;
    assign locked   = lock_q;
    assign line_len = len_q;

endmodule

// File: tb/tb_jtframe_scan2x_sync.sv
// Directed bench for jtframe_scan2x_sync: lock/relock, DE window, VS/LVBL
// alignment, HS loss, async reset, and cen every clock vs every second clock.
module tb_jtframe_scan2x_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pxl2_cen = 1'b0;
    logic [11:0] x2_pxl = 12'h000;
    logic        x2_HS = 1'b0;
    logic        VS = 1'b0;
    logic        LVBL = 1'b1;
    logic [11:0] vga_pxl;
    logic        vga_HS, vga_VS, vga_DE, locked;
    logic [9:0]  line_len;

    int          n_chk = 0;
    int          n_pass = 0;
    int          run;
    bit          slow;
    logic        vs_cur, lvbl_cur;
    int unsigned sig, sig_fast;

    jtframe_scan2x_sync dut (
        .clk      (clk),
        .rst      (rst),
        .pxl2_cen (pxl2_cen),
        .x2_pxl   (x2_pxl),
        .x2_HS    (x2_HS),
        .VS       (VS),
        .LVBL     (LVBL),
        .vga_pxl  (vga_pxl),
        .vga_HS   (vga_HS),
        .vga_VS   (vga_VS),
        .vga_DE   (vga_DE),
        .locked   (locked),
        .line_len (line_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One pxl2_cen tick; in slow mode an idle clock with junk inputs precedes it
    task automatic tick(input logic hs, input logic [11:0] px);
        if (slow) begin
            @(negedge clk);
            pxl2_cen = 1'b0;
            x2_HS    = ~hs;
            x2_pxl   = 12'($urandom);
            VS       = 1'($urandom);
            LVBL     = 1'($urandom);
        end
        @(negedge clk);
        pxl2_cen = 1'b1;
        x2_HS    = hs;
        x2_pxl   = px;
        VS       = vs_cur;
        LVBL     = lvbl_cur;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int bad = 0;
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            pxl2_cen = 1'($urandom);
            x2_HS    = 1'($urandom);
            x2_pxl   = 12'($urandom);
            VS       = 1'($urandom);
            LVBL     = 1'($urandom);
            @(posedge clk);
            #1;
            if ({vga_pxl, vga_HS, vga_VS, vga_DE, locked, line_len} != 26'd0) bad++;
        end
        check($sformatf("r%0d_rst_hold", run), bad, 0);
        @(negedge clk);
        pxl2_cen = 1'b0; x2_HS = 1'b0; x2_pxl = 12'h000; VS = 1'b0; LVBL = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("r%0d_rst_outs", run),
              {vga_pxl, vga_HS, vga_VS, vga_DE, locked, line_len}, 0);
        vs_cur   = 1'b0;
        lvbl_cur = 1'b1;
    endtask

    // Line of period p, HS width w; tick k=0 carries the HS rise (if w>0).
    // DE expected for k in 49..ll-16 when de_on (hcnt = k-1, window 48..ll-17).
    task automatic line_chk(input int ln, p, w, n, chg, input logic vs_n, lv_n, de_on,
                            input int ll, exp_lk, exp_ll, exp_de, exp_vs);
        int de_cnt = 0;
        int err = 0;
        int vs_cnt = 0;
        int ll0 = 0;
        logic lk0 = 1'b0;
        logic [11:0] px;
        logic hs, exp_de_b;
        for (int k = 0; k < n; k++) begin
            if (k == chg) begin
                vs_cur   = vs_n;
                lvbl_cur = lv_n;
            end
            px = {4'(ln + 1), 8'(k)};
            hs = (k < w);
            tick(hs, px);
            exp_de_b = de_on && (k >= 49) && (k <= ll - 16);
            if (vga_DE !== exp_de_b || vga_HS !== hs ||
                vga_pxl !== (exp_de_b ? px : 12'h000)) err++;
            de_cnt += int'(vga_DE);
            vs_cnt += int'(vga_VS);
            if (k == 0) begin
                lk0 = locked;
                ll0 = int'(line_len);
            end
            sig = (sig * 32'd33) ^ 32'({vga_pxl, vga_HS, vga_VS, vga_DE, locked, line_len});
        end
        check($sformatf("r%0d_ln%0d_locked", run, ln), lk0, exp_lk);
        if (exp_ll >= 0) check($sformatf("r%0d_ln%0d_len", run, ln), ll0, exp_ll);
        check($sformatf("r%0d_ln%0d_de_cnt", run, ln), de_cnt, exp_de);
        check($sformatf("r%0d_ln%0d_tick_err", run, ln), err, 0);
        check($sformatf("r%0d_ln%0d_vs_cnt", run, ln), vs_cnt, exp_vs);
    endtask

    initial begin
        for (run = 0; run < 2; run++) begin
            slow = (run == 1);
            sig  = 32'd0;
            do_reset();
            for (int i = 0; i < 4; i++) tick(1'b0, 12'h000);
            //       ln  p    w   n    chg  vs    lvbl  de_on ll   lk  len  de   vs
            line_chk(1,  512, 32, 512, -1,  1'b0, 1'b1, 1'b0, 0,   0,  0,   0,   0);
            line_chk(2,  512, 32, 512, -1,  1'b0, 1'b1, 1'b0, 0,   0,  512, 0,   0);
            line_chk(3,  512, 32, 512, -1,  1'b0, 1'b1, 1'b1, 512, 1,  512, 448, 0);
            line_chk(4,  500, 32, 500, -1,  1'b0, 1'b1, 1'b1, 512, 1,  512, 448, 0);
            line_chk(5,  500, 32, 500, -1,  1'b0, 1'b1, 1'b0, 500, 0,  500, 0,   0);
            line_chk(6,  500, 32, 500, -1,  1'b0, 1'b1, 1'b1, 500, 1,  500, 436, 0);
            line_chk(7,  500, 32, 500, 200, 1'b1, 1'b1, 1'b1, 500, 1,  500, 436, 0);
            line_chk(8,  500, 32, 500, 100, 1'b0, 1'b0, 1'b1, 500, 1,  500, 436, 500);
            line_chk(9,  500, 32, 500, 300, 1'b0, 1'b1, 1'b0, 500, 1,  500, 0,   0);
            line_chk(10, 500, 32, 500, -1,  1'b0, 1'b1, 1'b1, 500, 1,  500, 436, 0);
            line_chk(11, 1100, 0, 1100, -1, 1'b0, 1'b1, 1'b0, 500, 1,  500, 0,   0);
            check($sformatf("r%0d_hs_lost_locked", run), locked, 0);
            check($sformatf("r%0d_hs_lost_de", run), vga_DE, 0);
            line_chk(12, 512, 32, 512, -1,  1'b0, 1'b1, 1'b0, 512, 0,  -1,  0,   0);
            line_chk(13, 512, 32, 512, -1,  1'b0, 1'b1, 1'b0, 512, 0,  512, 0,   0);
            line_chk(14, 512, 32, 512, -1,  1'b0, 1'b1, 1'b1, 512, 1,  512, 448, 0);
            line_chk(15, 512, 32, 100, -1,  1'b0, 1'b1, 1'b1, 512, 1,  512, 51,  0);
            if (run == 0) sig_fast = sig;
            else check("cen2_vs_cen1_signature", sig, sig_fast);
            #2;
            rst = 1'b1;
            #1;
            check($sformatf("r%0d_async_rst", run),
                  {vga_pxl, vga_HS, vga_VS, vga_DE, locked, line_len}, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
